// File: rtl/axi_stream_remove_header_if.sv
// Bundle of every stream, strip-count and header-side signal of the header-remove stage.
// A transfer happens on any channel in a cycle where its valid and ready are both high at the rising edge.
interface axi_stream_remove_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;
  logic                    valid_strip;
  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;
  logic                    ready_strip;
  logic [DATA_WD-1:0]      header_out;
  logic [DATA_BYTE_WD-1:0] header_keep;
  logic                    header_valid;
  logic [1:0]              state_dbg;

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out, valid_strip, byte_strip_cnt,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_strip,
           header_out, header_keep, header_valid, state_dbg
  );

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out, valid_strip, byte_strip_cnt,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_strip,
           header_out, header_keep, header_valid, state_dbg
  );
endinterface

// File: rtl/axi_stream_remove_header.sv
// Strips N leading header bytes from each AXI-Stream packet, realigns the payload to full
// beats (MSB-first byte order) and reports the stripped bytes on a one-cycle side output.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                       clk,
  input logic                       rst,
  axi_stream_remove_header_if.slave bus
);
  localparam int CW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FIRST = 2'd1, BODY = 2'd2, FLUSH = 2'd3} state_t;

  state_t                  state_q;
  logic [BYTE_CNT_WD-1:0]  n_q;
  logic [DATA_WD-1:0]      rem_q;
  logic [CW-1:0]           flush_cnt_q;
  logic                    valid_out_q;
  logic [DATA_WD-1:0]      data_out_q;
  logic [DATA_BYTE_WD-1:0] keep_out_q;
  logic                    last_out_q;
  logic [DATA_WD-1:0]      header_q;
  logic [DATA_BYTE_WD-1:0] header_keep_q;
  logic                    header_valid_q;

  function automatic logic [DATA_BYTE_WD-1:0] top_ones(input logic [CW-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < int'(cnt)) m[DATA_BYTE_WD-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  logic                    can_load;
  logic                    in_hs;
  logic                    pass;
  logic                    v_gt_n;
  logic [CW-1:0]           v_d;
  logic [CW-1:0]           n_ext;
  logic [CW-1:0]           hdr_cnt_d;
  logic [CW-1:0]           tail_sh_d;
  logic [CW-1:0]           last_cnt_d;
  logic [CW-1:0]           extra_cnt_d;
  logic [DATA_WD-1:0]      rem_d;
  logic [DATA_WD-1:0]      combined_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_d;

  assign can_load    = ~valid_out_q | bus.ready_out;
  assign in_hs       = bus.valid_in & bus.ready_in;
  assign pass        = (n_q == '0);
  assign v_d         = popcount(bus.keep_in);
  assign n_ext       = {1'b0, n_q};
  assign v_gt_n      = (v_d > n_ext);
  assign hdr_cnt_d   = v_gt_n ? n_ext : v_d;
  assign hdr_keep_d  = top_ones(hdr_cnt_d);
  assign extra_cnt_d = v_d - n_ext;
  // Payload bytes of a closing beat: the held DW-N remainder bytes plus the v valid new bytes.
  assign last_cnt_d  = CW'(DATA_BYTE_WD) - n_ext + v_d;
  assign tail_sh_d   = CW'(DATA_BYTE_WD) - n_ext;
  assign rem_d       = bus.data_in << {n_q, 3'b000};
  assign combined_d  = rem_q | (bus.data_in >> {tail_sh_d, 3'b000});

  assign bus.ready_in     = ((state_q == FIRST) || (state_q == BODY)) && can_load;
  assign bus.ready_strip  = (state_q == IDLE);
  assign bus.valid_out    = valid_out_q;
  assign bus.data_out     = data_out_q;
  assign bus.keep_out     = keep_out_q;
  assign bus.last_out     = last_out_q;
  assign bus.header_out   = header_q;
  assign bus.header_keep  = header_keep_q;
  assign bus.header_valid = header_valid_q;
  assign bus.state_dbg    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      rem_q          <= '0;
      flush_cnt_q    <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      header_q       <= '0;
      header_keep_q  <= '0;
      header_valid_q <= 1'b0;
    end else begin
      header_valid_q <= 1'b0;
      if (valid_out_q && bus.ready_out) valid_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.valid_strip) begin
            n_q     <= bus.byte_strip_cnt;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          if (in_hs) begin
            header_q       <= bus.data_in & byte_mask(hdr_keep_d);
            header_keep_q  <= hdr_keep_d;
            header_valid_q <= 1'b1;
            rem_q          <= rem_d;
            if (pass) begin
              valid_out_q <= 1'b1;
              data_out_q  <= bus.data_in;
              keep_out_q  <= bus.keep_in;
              last_out_q  <= bus.last_in;
            end else if (bus.last_in && v_gt_n) begin
              valid_out_q <= 1'b1;
              data_out_q  <= rem_d & byte_mask(top_ones(extra_cnt_d));
              keep_out_q  <= top_ones(extra_cnt_d);
              last_out_q  <= 1'b1;
            end
            state_q <= bus.last_in ? IDLE : BODY;
          end
        end
        BODY: begin
          if (in_hs) begin
            rem_q       <= rem_d;
            valid_out_q <= 1'b1;
            if (pass) begin
              data_out_q <= bus.data_in;
              keep_out_q <= bus.keep_in;
              last_out_q <= bus.last_in;
              if (bus.last_in) state_q <= IDLE;
            end else if (!bus.last_in || v_gt_n) begin
              data_out_q <= combined_d;
              keep_out_q <= '1;
              last_out_q <= 1'b0;
              if (bus.last_in) begin
                flush_cnt_q <= extra_cnt_d;
                state_q     <= FLUSH;
              end
            end else begin
              data_out_q <= combined_d & byte_mask(top_ones(last_cnt_d));
              keep_out_q <= top_ones(last_cnt_d);
              last_out_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            valid_out_q <= 1'b1;
            data_out_q  <= rem_q & byte_mask(top_ones(flush_cnt_q));
            keep_out_q  <= top_ones(flush_cnt_q);
            last_out_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed and random packets through the header-remove stage; a byte-stream model fills
// expected queues for output beats and header pulses, which monitors pop on every transfer.
module tb_axi_stream_remove_header;
  localparam int DW  = 32;
  localparam int DBW = 4;
  localparam int W   = DW + DBW + 1;
  localparam int HW  = DW + DBW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_stream_remove_header_if #(.DATA_WD(DW)) bus ();

  axi_stream_remove_header #(.DATA_WD(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ro_mode  = 0;  // 0: ready_out high, 1: toggle every cycle, 2: held low

  logic [W-1:0]  exp_q[$];
  logic [HW-1:0] hdr_q[$];
  logic [31:0]   pd[8];
  logic [3:0]    pk[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ready_out has a single driver; it changes just after each rising edge
  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ro_mode)
        1:       bus.ready_out = ~bus.ready_out;
        2:       bus.ready_out = 1'b0;
        default: bus.ready_out = 1'b1;
      endcase
    end
  end

  logic         held_v = 1'b0;
  logic [W-1:0] held;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("stall_hold", {bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}, {1'b1, held});
      if (bus.valid_out && bus.ready_out) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          chk("out_beat", {bus.data_out, bus.keep_out, bus.last_out}, exp_q.pop_front());
      end
      held_v = bus.valid_out && !bus.ready_out;
      held   = {bus.data_out, bus.keep_out, bus.last_out};
      if (bus.header_valid) begin
        chk("hdr_expected", hdr_q.size() > 0, 1);
        if (hdr_q.size() > 0)
          chk("header", {bus.header_out, bus.header_keep}, hdr_q.pop_front());
      end
    end
  end

  // Byte-stream reference: header = first min(N,total) bytes, payload repacked four per beat
  task automatic model(input int n, input int nb);
    logic [7:0]  bs[$];
    logic [31:0] d;
    logic [3:0]  k;
    int          hc;
    int          pl;
    for (int b = 0; b < nb; b++)
      for (int i = 0; i < 4; i++)
        if (pk[b][3-i]) bs.push_back(pd[b][31-8*i -: 8]);
    hc = (n < bs.size()) ? n : bs.size();
    d = '0;
    k = '0;
    for (int i = 0; i < hc; i++) begin
      d[31-8*i -: 8] = bs[i];
      k[3-i] = 1'b1;
    end
    hdr_q.push_back({d, k});
    if (n == 0) begin
      for (int b = 0; b < nb; b++) exp_q.push_back({pd[b], pk[b], b == nb - 1});
    end else begin
      pl = bs.size() - hc;
      for (int s = 0; s < pl; s += 4) begin
        d = '0;
        k = '0;
        for (int j = 0; j < 4; j++)
          if (s + j < pl) begin
            d[31-8*j -: 8] = bs[hc+s+j];
            k[3-j] = 1'b1;
          end
        exp_q.push_back({d, k, s + 4 >= pl});
      end
    end
  endtask

  task automatic send_strip(input int n);
    logic ok;
    int   cyc;
    bus.valid_strip    = 1'b1;
    bus.byte_strip_cnt = 2'(n);
    cyc = 0;
    do begin
      @(negedge clk);
      ok = bus.ready_strip;
      @(posedge clk);
      #1;
      cyc++;
    end while (!ok && cyc < 200);
    chk("strip_accepted", ok, 1);
    bus.valid_strip = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic ok;
    int   cyc;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    cyc = 0;
    do begin
      @(negedge clk);
      ok = bus.ready_in;
      if (cyc == 0) chk("strip_low_in_pkt", bus.ready_strip, 0);
      @(posedge clk);
      #1;
      cyc++;
    end while (!ok && cyc < 200);
    chk("beat_accepted", ok, 1);
  endtask

  task automatic run_packet(input int n, input int nb);
    model(n, nb);
    send_strip(n);
    for (int b = 0; b < nb; b++) send_beat(pd[b], pk[b], b == nb - 1);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || hdr_q.size() != 0 || !bus.ready_strip) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_in_time", cyc < 500, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] lk;
    int         n;
    int         nb;
    bus.valid_in       = 1'b0;
    bus.data_in        = '0;
    bus.keep_in        = '0;
    bus.last_in        = 1'b0;
    bus.valid_strip    = 1'b0;
    bus.byte_strip_cnt = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_out_regs", {bus.data_out, bus.keep_out, bus.last_out}, 0);
    chk("rst_hdr_regs", {bus.header_out, bus.header_keep, bus.header_valid}, 0);
    chk("rst_ready_in", bus.ready_in, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready_strip", bus.ready_strip, 1);

    // N=2, three beats, last holds exactly N bytes: no flush
    pd[0] = 32'hAABBCCDD; pk[0] = 4'hF;
    pd[1] = 32'hEEFF0011; pk[1] = 4'hF;
    pd[2] = 32'h22339999; pk[2] = 4'hC;
    run_packet(2, 3);
    wait_drain();

    // N=1, last beat longer than N: flush beat
    pd[0] = 32'h11223344; pk[0] = 4'hF;
    pd[1] = 32'h55667799; pk[1] = 4'hE;
    run_packet(1, 2);
    wait_drain();

    // N=0 pass-through
    pd[0] = 32'h01020304; pk[0] = 4'hF;
    pd[1] = 32'h05060708; pk[1] = 4'hF;
    pd[2] = 32'h09000000; pk[2] = 4'h8;
    run_packet(0, 3);
    wait_drain();

    // N=3 single beat, all bytes are header: no output beat
    pd[0] = 32'hAABBCC99; pk[0] = 4'hE;
    run_packet(3, 1);
    wait_drain();

    // N=1 single beat with payload left over
    pd[0] = 32'hAABBCC99; pk[0] = 4'hE;
    run_packet(1, 1);
    wait_drain();

    // N=2, four beats under a toggling ready_out
    ro_mode = 1;
    pd[0] = 32'h10203040; pk[0] = 4'hF;
    pd[1] = 32'h50607080; pk[1] = 4'hF;
    pd[2] = 32'h90A0B0C0; pk[2] = 4'hF;
    pd[3] = 32'hD0E0F077; pk[3] = 4'hE;
    run_packet(2, 4);
    wait_drain();
    ro_mode = 0;

    // reset while in BODY with an output beat stalled
    ro_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    hdr_q.push_back({32'hAABB0000, 4'hC});
    send_strip(2);
    send_beat(32'hAABBCCDD, 4'hF, 1'b0);
    send_beat(32'h11223344, 4'hF, 1'b0);
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid_out", bus.valid_out, 1);
    chk("pre_rst_state_body", bus.state_dbg, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid_out", bus.valid_out, 0);
    chk("async_rst_out_regs", {bus.data_out, bus.keep_out, bus.last_out}, 0);
    chk("async_rst_hdr_regs", {bus.header_out, bus.header_keep, bus.header_valid}, 0);
    chk("async_rst_ready_in", bus.ready_in, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ro_mode = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ready_strip", bus.ready_strip, 1);
    chk("post_rst_hdr_drained", hdr_q.size(), 0);
    pd[0] = 32'h0A0B0C0D; pk[0] = 4'hF;
    pd[1] = 32'h0E0F1011; pk[1] = 4'hF;
    pd[2] = 32'h12131415; pk[2] = 4'h8;
    run_packet(2, 3);
    wait_drain();

    // random packets
    for (int t = 0; t < 12; t++) begin
      ro_mode = $urandom_range(0, 1);
      n  = $urandom_range(0, 3);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        pd[b] = $urandom;
        pk[b] = 4'hF;
      end
      lk = 4'hF;
      lk = lk << (4 - $urandom_range(1, 4));
      pk[nb-1] = lk;
      run_packet(n, nb);
    end
    wait_drain();
    ro_mode = 0;

    chk("exp_q_empty", exp_q.size(), 0);
    chk("hdr_q_empty", hdr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_stream_remove_header.md
Name: axi_stream_remove_header

Overview:
- Receive-side counterpart of the header-insert stage. Sits directly downstream of it, or at the far end of the link.
- Strips a per-packet count of leading header bytes from an AXI-Stream packet and realigns the remaining payload to full beats.
- Reports the stripped header bytes on a one-cycle side output.
- Byte order is MSB-first: byte 0 of a beat is data[DATA_WD-1 -: 8]. Keep is MSB-aligned and contiguous.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8, at least 16).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input beat data.
- keep_in  in  DATA_BYTE_WD  input byte enables (all-ones except on the last beat).
- last_in  in  1  last beat of the input packet.
- ready_in  out  1  input beat accepted when high together with valid_in.
- valid_out  out  1  output beat valid (registered).
- data_out  out  DATA_WD  realigned data (registered).
- keep_out  out  DATA_BYTE_WD  output byte enables (registered, MSB-aligned).
- last_out  out  1  last beat of the output packet (registered).
- ready_out  in  1  downstream ready.
- valid_strip  in  1  strip-count request valid.
- byte_strip_cnt  in  BYTE_CNT_WD  number N of leading header bytes to remove, 0..DATA_BYTE_WD-1.
- ready_strip  out  1  strip-count accepted when high together with valid_strip.
- header_out  out  DATA_WD  stripped bytes, MSB-aligned, zero-filled (registered).
- header_keep  out  DATA_BYTE_WD  enables for header_out.
- header_valid  out  1  one-cycle pulse when header_out updates.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - valid_out, last_out, header_valid to 0.
  - data_out, keep_out, header_out, header_keep to 0.
  - Remainder register and count to 0.
  - A packet in flight is abandoned and the partial output is discarded.
- Handshakes:
  - AXI rules apply: a beat transfers on valid&ready.
  - Output signals stay stable while valid_out=1 and ready_out=0.
  - The output register may load when it is empty or being drained: can_load = ~valid_out | ready_out.
- FSM states:
  - IDLE
    - ready_strip=1, ready_in=0.
    - On a strip handshake, latch N and go to FIRST.
  - FIRST
    - ready_in = can_load.
    - On the first input beat, header_out = top N bytes with lower bytes zero, header_keep = N ones from the MSB, header_valid pulses next cycle.
    - The remaining bytes are held as rem, left-aligned.
    - If N=0, the beat goes straight to the output register (pass-through mode).
    - Go to BODY if ~last_in.
  - BODY
    - ready_in = can_load.
    - Each accepted beat produces an output {rem (DW-N bytes), top N bytes of the new beat}.
    - The new rem is the low DW-N bytes of the new beat.
    - Output latency is 1 cycle from the input handshake to valid_out.
  - FLUSH
    - ready_in=0.
    - When can_load, emit rem with keep = (v-N) ones from the MSB and last_out=1, then go to IDLE.
- Last-beat rules, with v = popcount(keep_in) on the last_in beat:
  - v <= N: the combined beat is the final one. keep_out = DW-N+v ones, last_out=1, then IDLE (no flush).
  - v > N: the combined beat has full keep and last_out=0, then FLUSH.
  - Single-beat packet with v <= N: no output beat at all. Only the header pulse is produced (header_keep = v ones), then IDLE.
  - Single-beat packet with v > N: one output beat with (v-N) bytes, last_out=1.
  - N=0: pure pass-through. keep and last are copied, with 1-cycle latency.
- Throughput: one beat per cycle while ready_out is held high. A flush costs one extra output cycle, during which ready_in=0.
- ready_strip is 0 outside IDLE. The next packet's strip count is only taken after the previous last beat has been loaded into the output register.

Test Plan (DATA_WD=32):
- N=2, input AABBCCDD, EEFF0011, 2233xxxx (keep 1100, last) -> header_out AABB0000 with keep 1100 pulsed; output CCDDEEFF (1111), then 00112233 (1111, last); no flush.
- N=1, input 11223344, 556677xx (keep 1110, last) -> output 22334455 (1111), then 66770000 (1100, last) via FLUSH; header 11000000 (1000).
- N=0, 3-beat packet with last keep 1000 -> bit-exact copy, each beat 1 cycle late; header_keep 0000.
- N=3, single beat AABBCCxx (keep 1110, last) -> no valid_out; header AABBCC00 (1110).
- N=2, 4-beat packet with ready_out toggling every cycle -> no lost or duplicated beats; outputs hold while stalled; ready_strip stays low until the final beat is loaded.
- Assert rst while in BODY with valid_out=1 -> all outputs 0 on the same cycle; ready_strip=1 after release; the next packet is stripped correctly.
